// File: rtl/palette_pipe.sv
// Two-stage colour lookup: per-lane iteration counts map to RGB through a
// double-buffered, rotatable palette, with a global valid/ready stall.
module palette_pipe #(
    parameter int DATA_WIDTH    = 10,
    parameter int RGB_SIZE      = 24,
    parameter int MAX_ITERATION = 50,
    parameter int NUM_ENGINES   = 30,
    localparam int IDX_W = (MAX_ITERATION > 1) ? $clog2(MAX_ITERATION) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_ENGINES-1:0][DATA_WIDTH-1:0] iterations,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_ENGINES-1:0][RGB_SIZE-1:0]   rgb_val,
    input  logic                                   pal_wr_en,
    input  logic [IDX_W-1:0]                       pal_wr_addr,
    input  logic [RGB_SIZE-1:0]                    pal_wr_data,
    input  logic                                   pal_swap,
    input  logic                                   offset_wr_en,
    input  logic [IDX_W-1:0]                       offset_wr_data,
    input  logic                                   inset_wr_en,
    input  logic [RGB_SIZE-1:0]                    inset_wr_data,
    output logic                                   active_bank
);

    localparam logic [IDX_W:0] MAX_W = (IDX_W+1)'(MAX_ITERATION);

    logic [RGB_SIZE-1:0] bank0 [MAX_ITERATION];
    logic [RGB_SIZE-1:0] bank1 [MAX_ITERATION];

    logic [IDX_W-1:0]    offset;
    logic [RGB_SIZE-1:0] inset_color;

    logic                                 s1_valid;
    logic                                 s1_bank;
    logic [NUM_ENGINES-1:0]               s1_inset;
    logic [NUM_ENGINES-1:0][IDX_W-1:0]    s1_idx;
    logic [RGB_SIZE-1:0]                  s1_color;

    logic                                 advance;
    logic [NUM_ENGINES-1:0]               lane_inset;
    logic [NUM_ENGINES-1:0][IDX_W-1:0]    lane_idx;
    logic [NUM_ENGINES-1:0][RGB_SIZE-1:0] lane_rgb;

    // Any sum of two in-range indices is below 2*MAX_ITERATION, so a single
    // conditional subtract is a full modulo.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] sum);
        return (sum >= MAX_W) ? IDX_W'(sum - MAX_W) : IDX_W'(sum);
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        lane_inset = '0;
        lane_idx   = '0;
        lane_rgb   = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            lane_inset[k] = 32'(iterations[k]) >= 32'(MAX_ITERATION);
            lane_idx[k]   = wrap_idx({1'b0, iterations[k][IDX_W-1:0]} + {1'b0, offset});
            // The tag captured in S1 picks the bank, not the live active_bank.
            lane_rgb[k]   = s1_inset[k] ? s1_color
                          : (s1_bank ? bank1[s1_idx[k]] : bank0[s1_idx[k]]);
        end
    end

    // NOTE: palette storage has no reset; it is plain RAM and is written before use.
    always_ff @(posedge clk) begin
        if (pal_wr_en && ({1'b0, pal_wr_addr} < MAX_W)) begin
            if (active_bank)
                bank0[pal_wr_addr] <= pal_wr_data;
            else
                bank1[pal_wr_addr] <= pal_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank <= 1'b0;
            offset      <= '0;
            inset_color <= '0;
        end else begin
            if (pal_swap)
                active_bank <= ~active_bank;
            if (offset_wr_en)
                offset <= wrap_idx({1'b0, offset_wr_data});
            if (inset_wr_en)
                inset_color <= inset_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_bank   <= 1'b0;
            s1_inset  <= '0;
            s1_idx    <= '0;
            s1_color  <= '0;
            out_valid <= 1'b0;
            rgb_val   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_bank  <= active_bank;
                s1_inset <= lane_inset;
                s1_idx   <= lane_idx;
                s1_color <= inset_color;
            end
            if (s1_valid)
                rgb_val <= lane_rgb;
        end
    end

endmodule

// File: tb/tb_palette_pipe.sv
// Directed bench for palette_pipe: latency, in-set handling, rotation,
// stall behaviour, bank swapping and mid-run reset.
module tb_palette_pipe;

    localparam int DW = 10;
    localparam int RW = 24;
    localparam int MI = 50;
    localparam int NE = 30;
    localparam int IW = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [NE-1:0][DW-1:0]  iterations;
    logic                   out_valid;
    logic                   out_ready;
    logic [NE-1:0][RW-1:0]  rgb_val;
    logic                   pal_wr_en;
    logic [IW-1:0]          pal_wr_addr;
    logic [RW-1:0]          pal_wr_data;
    logic                   pal_swap;
    logic                   offset_wr_en;
    logic [IW-1:0]          offset_wr_data;
    logic                   inset_wr_en;
    logic [RW-1:0]          inset_wr_data;
    logic                   active_bank;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [NE-1:0][DW-1:0] vec;
    logic [NE-1:0][RW-1:0] got_rgb;
    logic                  got_valid;

    palette_pipe #(
        .DATA_WIDTH(DW), .RGB_SIZE(RW), .MAX_ITERATION(MI), .NUM_ENGINES(NE)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .iterations(iterations),
        .out_valid(out_valid), .out_ready(out_ready), .rgb_val(rgb_val),
        .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
        .pal_swap(pal_swap),
        .offset_wr_en(offset_wr_en), .offset_wr_data(offset_wr_data),
        .inset_wr_en(inset_wr_en), .inset_wr_data(inset_wr_data),
        .active_bank(active_bank)
    );

    always #5 clk = ~clk;

    // Bank 1 is loaded with pattern A, bank 0 with pattern B.
    function automatic logic [RW-1:0] pal_a(input int i);
        return RW'(i) << 16;
    endfunction

    function automatic logic [RW-1:0] pal_b(input int i);
        return RW'(i) << 8;
    endfunction

    task automatic clear_side();
        pal_wr_en    = 1'b0;
        pal_swap     = 1'b0;
        offset_wr_en = 1'b0;
        inset_wr_en  = 1'b0;
    endtask

    task automatic write_pal(input int addr, input logic [RW-1:0] data);
        pal_wr_en   = 1'b1;
        pal_wr_addr = IW'(addr);
        pal_wr_data = data;
        @(negedge clk);
        pal_wr_en   = 1'b0;
    endtask

    // Presents one beat for one cycle (sidebands set by the caller ride along),
    // then captures the output two cycles after presentation.
    task automatic run_beat(input logic [NE-1:0][DW-1:0] v);
        in_valid   = 1'b1;
        iterations = v;
        @(negedge clk);
        in_valid = 1'b0;
        clear_side();
        @(negedge clk);
        got_rgb   = rgb_val;
        got_valid = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (rgb_val !== '0) begin tests_failed++; $display("FAIL reset_rgb: got %h want 0", rgb_val[0]); end
        tests_run++; if (active_bank !== 1'b0) begin tests_failed++; $display("FAIL reset_bank: got %b want 0", active_bank); end
        rst = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < MI; i++) write_pal(i, pal_a(i));
        pal_swap = 1'b1;
        @(negedge clk);
        pal_swap = 1'b0;
        tests_run++; if (active_bank !== 1'b1) begin tests_failed++; $display("FAIL basic_swap: got %b want 1", active_bank); end
        for (int k = 0; k < NE; k++) vec[k] = DW'(k);
        in_valid   = 1'b1;
        iterations = vec;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_lat1: got %b want 0", out_valid); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_lat2: got %b want 1", out_valid); end
        for (int k = 0; k < NE; k++) begin
            tests_run++; if (rgb_val[k] !== pal_a(k)) begin tests_failed++; $display("FAIL basic_lane%0d: got %h want %h", k, rgb_val[k], pal_a(k)); end
        end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_bubble: got %b want 0", out_valid); end
        for (int i = 0; i < MI; i++) write_pal(i, pal_b(i));
        tests_run++; if (active_bank !== 1'b1) begin tests_failed++; $display("FAIL basic_bank_hold: got %b want 1", active_bank); end
    endtask

    task automatic test_inset();
        inset_wr_en = 1'b1; inset_wr_data = 24'h000000;
        @(negedge clk);
        clear_side();
        for (int k = 0; k < NE; k++) vec[k] = DW'(k);
        vec[0] = DW'(50); vec[1] = DW'(1023); vec[2] = DW'(49);
        run_beat(vec);
        tests_run++; if (got_valid !== 1'b1) begin tests_failed++; $display("FAIL inset_valid: got %b want 1", got_valid); end
        tests_run++; if (got_rgb[0] !== 24'h000000) begin tests_failed++; $display("FAIL inset_50: got %h want 000000", got_rgb[0]); end
        tests_run++; if (got_rgb[1] !== 24'h000000) begin tests_failed++; $display("FAIL inset_1023: got %h want 000000", got_rgb[1]); end
        tests_run++; if (got_rgb[2] !== 24'h310000) begin tests_failed++; $display("FAIL inset_49: got %h want 310000", got_rgb[2]); end
        tests_run++; if (got_rgb[3] !== 24'h030000) begin tests_failed++; $display("FAIL inset_lane3: got %h want 030000", got_rgb[3]); end
        inset_wr_en = 1'b1; inset_wr_data = 24'hABCDEF;
        @(negedge clk);
        clear_side();
        // A load in the capture cycle must not affect that beat.
        inset_wr_en = 1'b1; inset_wr_data = 24'h123456;
        run_beat(vec);
        tests_run++; if (got_rgb[0] !== 24'hABCDEF) begin tests_failed++; $display("FAIL inset_same_cycle: got %h want abcdef", got_rgb[0]); end
        tests_run++; if (got_rgb[1] !== 24'hABCDEF) begin tests_failed++; $display("FAIL inset_same_cycle1: got %h want abcdef", got_rgb[1]); end
        run_beat(vec);
        tests_run++; if (got_rgb[0] !== 24'h123456) begin tests_failed++; $display("FAIL inset_next: got %h want 123456", got_rgb[0]); end
        tests_run++; if (got_rgb[2] !== 24'h310000) begin tests_failed++; $display("FAIL inset_next_49: got %h want 310000", got_rgb[2]); end
    endtask

    task automatic test_offset();
        vec = '0;
        vec[0] = DW'(47);
        offset_wr_en = 1'b1; offset_wr_data = IW'(5);
        @(negedge clk);
        clear_side();
        run_beat(vec);
        tests_run++; if (got_rgb[0] !== 24'h020000) begin tests_failed++; $display("FAIL offset5_47: got %h want 020000", got_rgb[0]); end
        tests_run++; if (got_rgb[1] !== 24'h050000) begin tests_failed++; $display("FAIL offset5_0: got %h want 050000", got_rgb[1]); end
        offset_wr_en = 1'b1; offset_wr_data = IW'(0);
        run_beat(vec);
        tests_run++; if (got_rgb[0] !== 24'h020000) begin tests_failed++; $display("FAIL offset_same_cycle: got %h want 020000", got_rgb[0]); end
        run_beat(vec);
        tests_run++; if (got_rgb[0] !== 24'h2F0000) begin tests_failed++; $display("FAIL offset0_47: got %h want 2f0000", got_rgb[0]); end
        tests_run++; if (got_rgb[1] !== 24'h000000) begin tests_failed++; $display("FAIL offset0_0: got %h want 000000", got_rgb[1]); end
        // 63 reduces to 13.
        offset_wr_en = 1'b1; offset_wr_data = IW'(63);
        @(negedge clk);
        clear_side();
        vec[0] = DW'(40); vec[2] = DW'(49);
        run_beat(vec);
        tests_run++; if (got_rgb[0] !== 24'h030000) begin tests_failed++; $display("FAIL offset63_40: got %h want 030000", got_rgb[0]); end
        tests_run++; if (got_rgb[1] !== 24'h0D0000) begin tests_failed++; $display("FAIL offset63_0: got %h want 0d0000", got_rgb[1]); end
        tests_run++; if (got_rgb[2] !== 24'h0C0000) begin tests_failed++; $display("FAIL offset63_49: got %h want 0c0000", got_rgb[2]); end
        offset_wr_en = 1'b1; offset_wr_data = IW'(0);
        @(negedge clk);
        clear_side();
    endtask

    task automatic test_back_to_back();
        vec = '0;
        vec[0] = DW'(10);
        in_valid = 1'b1; iterations = vec;
        @(negedge clk);
        vec[0] = DW'(11); iterations = vec;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h0A0000) begin tests_failed++; $display("FAIL b2b_first: got v=%b %h want v=1 0a0000", out_valid, rgb_val[0]); end
        vec[0] = DW'(12); iterations = vec;
        out_ready = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_stall_ready: got %b want 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h0A0000) begin tests_failed++; $display("FAIL b2b_hold%0d: got v=%b %h want v=1 0a0000", c, out_valid, rgb_val[0]); end
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready%0d: got %b want 0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h0B0000) begin tests_failed++; $display("FAIL b2b_second: got v=%b %h want v=1 0b0000", out_valid, rgb_val[0]); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h0C0000) begin tests_failed++; $display("FAIL b2b_third: got v=%b %h want v=1 0c0000", out_valid, rgb_val[0]); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_swap();
        vec = '0;
        vec[0] = DW'(3);
        in_valid = 1'b1; iterations = vec;
        @(negedge clk);
        vec[0] = DW'(7); iterations = vec;
        @(negedge clk);
        // Beat lane0=3 in S2, lane0=7 in S1; stall and swap.
        in_valid = 1'b0; out_ready = 1'b0; pal_swap = 1'b1;
        tests_run++; if (active_bank !== 1'b1) begin tests_failed++; $display("FAIL swap_before: got %b want 1", active_bank); end
        @(negedge clk);
        pal_swap = 1'b0;
        tests_run++; if (active_bank !== 1'b0) begin tests_failed++; $display("FAIL swap_toggle: got %b want 0", active_bank); end
        tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h030000) begin tests_failed++; $display("FAIL swap_head: got v=%b %h want v=1 030000", out_valid, rgb_val[0]); end
        out_ready = 1'b1;
        in_valid = 1'b1; iterations = vec;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h070000) begin tests_failed++; $display("FAIL swap_old_bank: got v=%b %h want v=1 070000", out_valid, rgb_val[0]); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h000700) begin tests_failed++; $display("FAIL swap_new_bank: got v=%b %h want v=1 000700", out_valid, rgb_val[0]); end
        // Write plus swap in one cycle lands in the pre-swap shadow (bank 1).
        pal_wr_en = 1'b1; pal_wr_addr = IW'(20); pal_wr_data = 24'h5A5A5A; pal_swap = 1'b1;
        @(negedge clk);
        clear_side();
        tests_run++; if (active_bank !== 1'b1) begin tests_failed++; $display("FAIL wrswap_bank: got %b want 1", active_bank); end
        vec = '0;
        vec[0] = DW'(20); vec[1] = DW'(21);
        run_beat(vec);
        tests_run++; if (got_rgb[0] !== 24'h5A5A5A) begin tests_failed++; $display("FAIL wrswap_data: got %h want 5a5a5a", got_rgb[0]); end
        tests_run++; if (got_rgb[1] !== 24'h150000) begin tests_failed++; $display("FAIL wrswap_other: got %h want 150000", got_rgb[1]); end
    endtask

    task automatic test_reset_mid();
        vec = '0;
        vec[0] = DW'(5);
        in_valid = 1'b1; iterations = vec;
        @(negedge clk);
        vec[0] = DW'(6); iterations = vec;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || rgb_val[0] !== 24'h050000) begin tests_failed++; $display("FAIL rmid_pre: got v=%b %h want v=1 050000", out_valid, rgb_val[0]); end
        #2;
        rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        tests_run++; if (rgb_val !== '0) begin tests_failed++; $display("FAIL rmid_rgb: got %h want 0", rgb_val[0]); end
        tests_run++; if (active_bank !== 1'b0) begin tests_failed++; $display("FAIL rmid_bank: got %b want 0", active_bank); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_stale%0d: got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        iterations = '0;
        out_ready = 1'b1;
        pal_wr_addr = '0;
        pal_wr_data = '0;
        offset_wr_data = '0;
        inset_wr_data = '0;
        vec = '0;
        got_rgb = '0;
        got_valid = 1'b0;
        clear_side();
        test_reset();
        test_basic();
        test_inset();
        test_offset();
        test_back_to_back();
        test_swap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/palette_pipe.md
PALETTE_PIPE -- requirements
Module: palette_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, width of each iteration count.
REQ-002 SHALL have parameter RGB_SIZE, default 24, width of each colour word.
REQ-003 SHALL have parameter MAX_ITERATION, default 50, palette depth; counts >= MAX_ITERATION are "in set".
REQ-004 SHALL have parameter NUM_ENGINES, default 30, number of lanes per beat.
REQ-005 SHALL have derived localparam IDX_W = clog2(MAX_ITERATION), minimum 1.
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports in_valid in 1, in_ready out 1: input beat handshake.
REQ-009 SHALL have port iterations  in  [NUM_ENGINES][DATA_WIDTH]  per-lane iteration counts.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1: output beat handshake.
REQ-011 SHALL have port rgb_val  out  [NUM_ENGINES][RGB_SIZE]  per-lane colours, registered.
REQ-012 SHALL have ports pal_wr_en in 1, pal_wr_addr in IDX_W, pal_wr_data in RGB_SIZE: shadow-palette write.
REQ-013 SHALL have port pal_swap  in  1  single-cycle request to exchange active and shadow banks.
REQ-014 SHALL have ports offset_wr_en in 1, offset_wr_data in IDX_W: palette rotation offset load.
REQ-015 SHALL have ports inset_wr_en in 1, inset_wr_data in RGB_SIZE: in-set colour load.
REQ-016 SHALL have port active_bank  out  1  currently active palette bank.

Function
REQ-017 SHALL hold two palette banks of MAX_ITERATION x RGB_SIZE; reads use the active bank only, writes target the shadow bank only.
REQ-018 SHALL be a 2-stage pipeline: S1 registers per-lane index, in-set flag and bank tag; S2 registers rgb_val.
REQ-019 SHALL define advance = !out_valid || out_ready; in_ready = advance (combinational, global stall).
REQ-020 SHALL accept a beat when in_valid && in_ready; the beat appears on rgb_val with out_valid exactly 2 cycles later when never stalled.
REQ-021 SHALL freeze S1 and S2 contents while advance = 0; rgb_val and out_valid SHALL hold stable until out_ready.
REQ-022 SHALL insert bubbles (valid 0) into S1 when advance && !in_valid; throughput 1 beat/cycle with out_ready held high.
REQ-023 SHALL compute per lane in S1: in-set = (iterations >= MAX_ITERATION); else index = (iterations + offset) mod MAX_ITERATION via one conditional subtract, in IDX_W+1 bits.
REQ-024 SHALL drive in-set lanes with the in-set colour register sampled at S1 capture, independent of palette contents.
REQ-025 SHALL tag each beat in S1 with active_bank at capture; S2 reads that tagged bank, so one beat never mixes palettes.
REQ-026 SHALL toggle active_bank on the cycle after pal_swap = 1; a swap during stall still takes effect, affecting only beats captured afterwards.
REQ-027 SHALL, on pal_wr_en && pal_swap in the same cycle, write into the pre-swap shadow bank (the data becomes active after the swap).
REQ-028 SHALL ignore pal_wr_addr >= MAX_ITERATION (no write).
REQ-029 SHALL apply offset and in-set colour loads to beats captured in S1 on later cycles only; out-of-range offset_wr_data is reduced mod MAX_ITERATION.

Reset
REQ-030 SHALL on rst clear: S1/S2 valid, out_valid = 0, rgb_val = 0, active_bank = 0, offset = 0, in-set colour = 0.
REQ-031 SHALL not reset palette memory contents; contents are undefined until written.
REQ-032 SHALL discard in-flight beats on rst mid-operation; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-033 SHALL pass: write shadow[i] = 0x010000*i for i<50, pulse pal_swap, feed iterations 0..29 -> rgb_val[k] = 0x010000*k, out_valid 2 cycles after acceptance.
REQ-034 SHALL pass: inset colour 0x000000, offset 0, lane iterations 50, 1023, 49 -> black, black, palette[49].
REQ-035 SHALL pass: offset 5, iteration 47 -> palette[2]; offset 0 afterward -> palette[47] on next beat only.
REQ-036 SHALL pass: out_ready low 3 cycles with 2 beats in flight -> in_ready 0, rgb_val stable, no beat lost or duplicated on release.
REQ-037 SHALL pass: pal_swap while a beat sits in S1 -> that beat uses old bank, next beat uses new bank, active_bank toggles one cycle after the pulse.
REQ-038 SHALL pass: rst asserted with out_valid 1 -> out_valid, rgb_val, active_bank 0 immediately; no stale beat emitted after release.
